// File: rtl/cpu_pkg.sv
// Shared types for the CPU test sequencer: sequencer states, load-beat kinds
// and default word widths.
package cpu_pkg;

    localparam int IW_DEF = 34;
    localparam int DW_DEF = 32;
    localparam int AW_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_CHECK_RD  = 3'd3,
        ST_CHECK_CMP = 3'd4,
        ST_DONE      = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        KIND_IMEM  = 2'b00,
        KIND_DMEM  = 2'b01,
        KIND_CHECK = 2'b10,
        KIND_RSVD  = 2'b11
    } ld_kind_t;

endpackage

// File: rtl/seq_check_table.sv
// Append-only table of {address, expected data} checks with a random-access
// read port. Entries are not reset; only the fill count is.
module seq_check_table #(
    parameter int NUM_CHECKS = 8,
    parameter int AW         = 16,
    parameter int DW         = 32,
    localparam int CNTW      = $clog2(NUM_CHECKS + 1),
    localparam int IDXW      = $clog2(NUM_CHECKS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            clear,
    input  logic            append,
    input  logic [AW-1:0]   app_addr,
    input  logic [DW-1:0]   app_data,
    input  logic [IDXW-1:0] rd_idx,
    output logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    output logic [CNTW-1:0] count,
    output logic            full
);

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(NUM_CHECKS);

    logic [AW-1:0]   addr_mem [NUM_CHECKS];
    logic [DW-1:0]   data_mem [NUM_CHECKS];
    logic [CNTW-1:0] count_q;
    logic [CNTW-1:0] count_d;

    assign full    = (count_q == FULL_CNT);
    assign count   = count_q;
    assign rd_addr = addr_mem[rd_idx];
    assign rd_data = data_mem[rd_idx];

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (append && !full) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (append && !full && !clear) begin
            addr_mem[count_q[IDXW-1:0]] <= app_addr;
            data_mem[count_q[IDXW-1:0]] <= app_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cpu_test_sequencer.sv
// Loads a tagged program/data/check stream into the CPU memories, runs the CPU
// until halt or timeout, then reads back every check and reports the verdict.
module cpu_test_sequencer
    import cpu_pkg::*;
#(
    parameter int IW         = IW_DEF,
    parameter int DW         = DW_DEF,
    parameter int AW         = AW_DEF,
    parameter int NUM_CHECKS = 8,
    parameter int TIMEOUT    = 4096,
    localparam int CW        = $clog2(TIMEOUT + 1),
    localparam int FW        = $clog2(NUM_CHECKS),
    localparam int CNTW      = $clog2(NUM_CHECKS + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [1:0]    ld_kind,
    input  logic          ld_last,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_wdata,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [IW-1:0] imem_wdata,
    output logic          dmem_we,
    output logic          dmem_re,
    output logic [AW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic [DW-1:0] dmem_rdata,
    input  logic          cpu_halt,
    output logic          cpu_reset,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [FW-1:0] fail_idx,
    output logic [CW-1:0] cycle_count,
    output seq_state_t    dbg_state
);

    localparam logic [CW-1:0] TIMEOUT_CNT = CW'(TIMEOUT);

    // Load stream handshake: a beat transfers on a cycle where ld_valid and
    // ld_ready are both 1; ld_ready depends only on state, never on ld_valid.
    seq_state_t    state_q, state_d;
    logic          last_q, last_d;
    logic          imem_we_q, imem_we_d;
    logic          dmem_we_q, dmem_we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [IW-1:0] wdata_q, wdata_d;
    logic [CW-1:0] cycle_q, cycle_d;
    logic          overflow_q, overflow_d;
    logic          mismatch_q, mismatch_d;
    logic          timeout_q, timeout_d;
    logic          pass_q, pass_d;
    logic [FW-1:0] fail_idx_q, fail_idx_d;
    logic [CNTW-1:0] idx_q, idx_d;

    logic            ld_xfer;
    logic            tbl_clear;
    logic            tbl_append;
    logic [AW-1:0]   tbl_rd_addr;
    logic [DW-1:0]   tbl_rd_data;
    logic [CNTW-1:0] tbl_count;
    logic            tbl_full;

    seq_check_table #(
        .NUM_CHECKS(NUM_CHECKS),
        .AW        (AW),
        .DW        (DW)
    ) u_check_table (
        .clk     (clk),
        .reset   (reset),
        .clear   (tbl_clear),
        .append  (tbl_append),
        .app_addr(ld_addr),
        .app_data(ld_wdata[DW-1:0]),
        .rd_idx  (idx_q[FW-1:0]),
        .rd_addr (tbl_rd_addr),
        .rd_data (tbl_rd_data),
        .count   (tbl_count),
        .full    (tbl_full)
    );

    // The cycle after the last beat stays in LOAD to retire its write.
    assign ld_ready    = (state_q == ST_LOAD) && !last_q;
    assign ld_xfer     = ld_valid && ld_ready;
    assign cpu_reset   = (state_q != ST_RUN);
    assign busy        = (state_q == ST_LOAD) || (state_q == ST_RUN) ||
                         (state_q == ST_CHECK_RD) || (state_q == ST_CHECK_CMP);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign timeout     = timeout_q;
    assign fail_idx    = fail_idx_q;
    assign cycle_count = cycle_q;
    assign dbg_state   = state_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_wdata  = wdata_q[DW-1:0];
    assign dmem_re     = (state_q == ST_CHECK_RD);
    assign dmem_addr   = (state_q == ST_CHECK_RD) ? tbl_rd_addr : addr_q;

    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        imem_we_d  = 1'b0;
        dmem_we_d  = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cycle_d    = cycle_q;
        overflow_d = overflow_q;
        mismatch_d = mismatch_q;
        timeout_d  = timeout_q;
        pass_d     = pass_q;
        fail_idx_d = fail_idx_q;
        idx_d      = idx_q;
        tbl_clear  = 1'b0;
        tbl_append = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d    = ST_LOAD;
                    last_d     = 1'b0;
                    cycle_d    = '0;
                    overflow_d = 1'b0;
                    mismatch_d = 1'b0;
                    timeout_d  = 1'b0;
                    pass_d     = 1'b0;
                    fail_idx_d = '0;
                    idx_d      = '0;
                    tbl_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (last_q) begin
                    state_d = ST_RUN;
                end else if (ld_xfer) begin
                    addr_d  = ld_addr;
                    wdata_d = ld_wdata;
                    last_d  = ld_last;
                    case (ld_kind_t'(ld_kind))
                        KIND_IMEM: imem_we_d = 1'b1;
                        KIND_DMEM: dmem_we_d = 1'b1;
                        KIND_CHECK: begin
                            if (tbl_full) begin
                                overflow_d = 1'b1;
                            end else begin
                                tbl_append = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                cycle_d = (cycle_q == TIMEOUT_CNT) ? cycle_q : cycle_q + 1'b1;
                idx_d   = '0;
                // Halt takes priority over a timeout landing in the same cycle.
                if (cpu_halt) begin
                    if (tbl_count == '0) begin
                        state_d = ST_DONE;
                        pass_d  = !overflow_q;
                    end else begin
                        state_d = ST_CHECK_RD;
                    end
                end else if (cycle_d == TIMEOUT_CNT) begin
                    state_d   = ST_DONE;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end
            end
            ST_CHECK_RD: begin
                state_d = ST_CHECK_CMP;
            end
            ST_CHECK_CMP: begin
                if ((dmem_rdata != tbl_rd_data) && !mismatch_q) begin
                    mismatch_d = 1'b1;
                    fail_idx_d = idx_q[FW-1:0];
                end
                idx_d = idx_q + 1'b1;
                if (idx_d == tbl_count) begin
                    state_d = ST_DONE;
                    pass_d  = !mismatch_d && !overflow_q;
                end else begin
                    state_d = ST_CHECK_RD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            last_q     <= 1'b0;
            imem_we_q  <= 1'b0;
            dmem_we_q  <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
            pass_q     <= 1'b0;
            fail_idx_q <= '0;
            idx_q      <= '0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            imem_we_q  <= imem_we_d;
            dmem_we_q  <= dmem_we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
            pass_q     <= pass_d;
            fail_idx_q <= fail_idx_d;
            idx_q      <= idx_d;
        end
    end

endmodule
